sgpr_recovery_ctrl: RTL

Controller sitting between the two lockstep cores' writeback ports and the shared GPR (sgpr) register file. It commits agreeing writebacks to the sgpr. On disagreement it halts both cores, discards the faulty write, and replays the full sgpr contents into both cores' private register files. It then releases the cores with a resume pulse.

---
 rtl/sgpr_pkg.sv | 14 +
 rtl/sgpr_recovery_ctrl_if.sv | 40 ++++
 rtl/sgpr_recovery_ctrl_wb_match.sv | 30 +++
 rtl/sgpr_recovery_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sgpr_pkg.sv
// Shared types and constants for the lockstep sgpr recovery controller.
package sgpr_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        RESTORE,
        RESUME
    } state_t;

endpackage

// File: rtl/sgpr_recovery_ctrl_if.sv
// Bundle of writeback, sgpr and restore signals between the cores/sgpr (master) and the controller (slave).
interface sgpr_recovery_ctrl_if
    import sgpr_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
);

    logic                     we_a_i;
    logic [REG_ADDR_W-1:0]    addr_a_i;
    logic [DATA_WIDTH-1:0]    data_a_i;
    logic                     we_b_i;
    logic [REG_ADDR_W-1:0]    addr_b_i;
    logic [DATA_WIDTH-1:0]    data_b_i;
    logic                     sgpr_we_o;
    logic [REG_ADDR_W-1:0]    sgpr_waddr_o;
    logic [DATA_WIDTH-1:0]    sgpr_wdata_o;
    logic [REG_ADDR_W-1:0]    sgpr_raddr_o;
    logic [DATA_WIDTH-1:0]    sgpr_rdata_i;
    logic                     halt_o;
    logic                     restore_we_o;
    logic [REG_ADDR_W-1:0]    restore_addr_o;
    logic [DATA_WIDTH-1:0]    restore_data_o;
    logic                     resume_o;
    logic                     error_o;
    logic [ERR_CNT_WIDTH-1:0] err_count_o;

    modport master (
        output we_a_i, addr_a_i, data_a_i, we_b_i, addr_b_i, data_b_i, sgpr_rdata_i,
        input  sgpr_we_o, sgpr_waddr_o, sgpr_wdata_o, sgpr_raddr_o, halt_o,
        input  restore_we_o, restore_addr_o, restore_data_o, resume_o, error_o, err_count_o
    );

    modport slave (
        input  we_a_i, addr_a_i, data_a_i, we_b_i, addr_b_i, data_b_i, sgpr_rdata_i,
        output sgpr_we_o, sgpr_waddr_o, sgpr_wdata_o, sgpr_raddr_o, halt_o,
        output restore_we_o, restore_addr_o, restore_data_o, resume_o, error_o, err_count_o
    );

endinterface

// File: rtl/sgpr_recovery_ctrl_wb_match.sv
// Combinational comparison of the two cores' writeback ports.
module wb_match
    import sgpr_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  we_a,
    input  logic [REG_ADDR_W-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  we_b,
    input  logic [REG_ADDR_W-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic                  match,
    output logic                  mismatch,
    output logic                  commit_valid
);

    logic both_we;
    logic same_write;

    always_comb begin
        both_we      = we_a & we_b;
        same_write   = (addr_a == addr_b) && (data_a == data_b);
        match        = (we_a == we_b) && (!both_we || same_write);
        mismatch     = !match;
        // x0 is hardwired zero, so an agreed write to it is dropped
        commit_valid = both_we && same_write && (addr_a != '0);
    end

endmodule

// File: rtl/sgpr_recovery_ctrl.sv
// Lockstep writeback checker: commits agreed writes, and on disagreement halts, replays x1..x31, then resumes.
// Build option: define SGPR_ERR_COUNT_EN to implement the saturating mismatch counter on err_count_o.
module sgpr_recovery_ctrl
    import sgpr_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8,
    parameter int HALT_DRAIN    = 2
) (
    input logic                 clk,
    input logic                 rst,
    sgpr_recovery_ctrl_if.slave bus
);

    localparam logic [3:0]            DRAIN_LOAD = 4'(HALT_DRAIN - 1);
    localparam logic [REG_ADDR_W-1:0] LAST_REG   = REG_ADDR_W'(NUM_REGS - 1);

    state_t                state_reg;
    logic [3:0]            drain_cnt_reg;
    logic [REG_ADDR_W-1:0] restore_cnt_reg;
    logic                  halt_reg;
    logic                  restore_we_reg;
    logic                  resume_reg;
    logic                  error_reg;
    logic                  sgpr_we_reg;
    logic [REG_ADDR_W-1:0] sgpr_waddr_reg;
    logic [DATA_WIDTH-1:0] sgpr_wdata_reg;
    logic                  match;
    logic                  mismatch;
    logic                  commit_valid;

    wb_match #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wb_match (
        .we_a         (bus.we_a_i),
        .addr_a       (bus.addr_a_i),
        .data_a       (bus.data_a_i),
        .we_b         (bus.we_b_i),
        .addr_b       (bus.addr_b_i),
        .data_b       (bus.data_b_i),
        .match        (match),
        .mismatch     (mismatch),
        .commit_valid (commit_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            drain_cnt_reg   <= '0;
            restore_cnt_reg <= '0;
            halt_reg        <= 1'b0;
            restore_we_reg  <= 1'b0;
            resume_reg      <= 1'b0;
            error_reg       <= 1'b0;
            sgpr_we_reg     <= 1'b0;
            sgpr_waddr_reg  <= '0;
            sgpr_wdata_reg  <= '0;
        end else begin
            sgpr_we_reg    <= 1'b0;
            sgpr_waddr_reg <= '0;
            sgpr_wdata_reg <= '0;
            resume_reg     <= 1'b0;
            case (state_reg)
                RUN: begin
                    if (mismatch) begin
                        state_reg     <= DRAIN;
                        halt_reg      <= 1'b1;
                        error_reg     <= 1'b1;
                        drain_cnt_reg <= DRAIN_LOAD;
                    end else if (match && commit_valid) begin
                        sgpr_we_reg    <= 1'b1;
                        sgpr_waddr_reg <= bus.addr_a_i;
                        sgpr_wdata_reg <= bus.data_a_i;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == '0) begin
                        state_reg       <= RESTORE;
                        restore_we_reg  <= 1'b1;
                        restore_cnt_reg <= REG_ADDR_W'(1);
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 4'd1;
                    end
                end
                RESTORE: begin
                    if (restore_cnt_reg == LAST_REG) begin
                        state_reg       <= RESUME;
                        halt_reg        <= 1'b0;
                        restore_we_reg  <= 1'b0;
                        restore_cnt_reg <= '0;
                        resume_reg      <= 1'b1;
                    end else begin
                        restore_cnt_reg <= restore_cnt_reg + REG_ADDR_W'(1);
                    end
                end
                RESUME: state_reg <= RUN;
                default: state_reg <= RUN;
            endcase
        end
    end

    // The counter parks at 0 outside RESTORE, so address outputs idle at 0 without extra muxing
    assign bus.sgpr_we_o      = sgpr_we_reg;
    assign bus.sgpr_waddr_o   = sgpr_waddr_reg;
    assign bus.sgpr_wdata_o   = sgpr_wdata_reg;
    assign bus.sgpr_raddr_o   = restore_cnt_reg;
    assign bus.halt_o         = halt_reg;
    assign bus.restore_we_o   = restore_we_reg;
    assign bus.restore_addr_o = restore_cnt_reg;
    assign bus.restore_data_o = restore_we_reg ? bus.sgpr_rdata_i : '0;
    assign bus.resume_o       = resume_reg;
    assign bus.error_o        = error_reg;

`ifdef SGPR_ERR_COUNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_cnt_reg;
    logic                     count_event;

    assign count_event = (state_reg == RUN) && mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if (count_event && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + ERR_CNT_WIDTH'(1);
        end
    end

    assign bus.err_count_o = err_cnt_reg;
`else
    assign bus.err_count_o = '0;
`endif

endmodule
